// File: rtl/fft_addr_sequencer.sv
// rtl/fft_addr_sequencer.sv - address/twiddle sequencer for an in-place radix-2 DIT FFT
// Walks every stage, issuing one butterfly request per handshake, with a drain gap between stages.
module fft_addr_sequencer #(
  parameter int ADDR_WIDTH = 13,
  parameter int PIPE_LAT   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [ADDR_WIDTH-1:0]           addr_a,
  output logic [ADDR_WIDTH-1:0]           addr_b,
  output logic [ADDR_WIDTH-2:0]           tw_idx,
  output logic [$clog2(ADDR_WIDTH)-1:0]   stage,
  output logic                            last,
  output logic                            busy,
  output logic                            done
);

  localparam int SW = $clog2(ADDR_WIDTH);
  localparam int CW = ADDR_WIDTH - 1;
  localparam int DW = $clog2(PIPE_LAT + 2);
  localparam logic [SW-1:0] LAST_STAGE = SW'(ADDR_WIDTH - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_n, stride, mask, addr_step;
  logic [ADDR_WIDTH-1:0]   stride_n, mask_n;
  logic [CW-1:0]           tw_n;
  logic [SW-1:0]           stage_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [DW-1:0]           drain, drain_n;
  logic                    done_n, stage_end, issue_n;

  // A group's lower half ends when all bits below the stage bit are set; skip the upper half.
  assign stride    = ADDR_WIDTH'(1) << stage;
  assign mask      = stride - ADDR_WIDTH'(1);
  assign addr_step = addr_a + ADDR_WIDTH'(1) + (((addr_a & mask) == mask) ? stride : '0);

  // Derived outputs are computed from next-state values so they register alongside addr_a.
  assign stride_n = ADDR_WIDTH'(1) << stage_n;
  assign mask_n   = stride_n - ADDR_WIDTH'(1);
  assign tw_n     = CW'((addr_n & mask_n) << (LAST_STAGE - stage_n));
  assign issue_n  = (state_n == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_a    <= '0;
      stage     <= '0;
      cnt       <= '0;
      drain     <= '0;
      addr_b    <= '0;
      tw_idx    <= '0;
      last      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr_a    <= addr_n;
      stage     <= stage_n;
      cnt       <= cnt_n;
      drain     <= drain_n;
      addr_b    <= issue_n ? (addr_n | stride_n) : '0;
      tw_idx    <= issue_n ? tw_n : '0;
      last      <= issue_n & (&cnt_n);
      out_valid <= issue_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr_a;
    stage_n   = stage;
    cnt_n     = cnt;
    drain_n   = drain;
    done_n    = 1'b0;
    stage_end = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          addr_n  = '0;
          stage_n = '0;
          cnt_n   = '0;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (&cnt) begin
            addr_n = '0;
            cnt_n  = '0;
            if (PIPE_LAT == 0) begin
              stage_end = 1'b1;
            end else begin
              state_n = DRAIN;
              drain_n = DRAIN_LOAD;
            end
          end else begin
            addr_n = addr_step;
            cnt_n  = cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain <= DW'(1)) begin
          stage_end = 1'b1;
        end else begin
          drain_n = drain - DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (stage_end) begin
      if (stage == LAST_STAGE) begin
        state_n = IDLE;
        stage_n = '0;
        done_n  = 1'b1;
      end else begin
        state_n = ISSUE;
        stage_n = stage + SW'(1);
      end
    end
  end

endmodule

// File: doc/fft_addr_sequencer.md
Name: fft_addr_sequencer

Overview:
- Sequencer for the shared-butterfly in-place radix-2 DIT FFT.
- After a start pulse it walks all ADDR_WIDTH stages. Each stage issues one butterfly request per handshake: an address pair plus a twiddle index.
- Group jumps (skipping the upper half of each butterfly group) are generated internally.
- Between stages it stalls for a programmable drain gap so butterfly write-back completes before the next stage reads.

Parameters:
- ADDR_WIDTH, 13, log2 of transform size N; also the number of stages.
- PIPE_LAT, 4, idle cycles inserted after the last handshake of every stage (butterfly read-to-write-back latency); 0 means no gap.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- out_ready  in  1  butterfly datapath accepts current request
- out_valid  out  1  request valid
- addr_a  out  ADDR_WIDTH  upper-butterfly (even) memory address
- addr_b  out  ADDR_WIDTH  lower-butterfly address, addr_a + 2^stage
- tw_idx  out  ADDR_WIDTH-1  twiddle ROM index
- stage  out  $clog2(ADDR_WIDTH)  current stage, 0..ADDR_WIDTH-1
- last  out  1  current request is the final butterfly of its stage
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse when the transform completes

Behaviour:
- Reset (async assert, sync-released): state=IDLE; all outputs 0; internal counters 0. Asserting rst_n low mid-transform aborts immediately with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE, start=1 -> ISSUE next cycle; stage=0, addr_a=0, butterfly count=0.
  - ISSUE: out_valid=1. A handshake (out_valid & out_ready) advances the request.
  - ISSUE, handshake with last=1 -> DRAIN, drain counter loaded with PIPE_LAT. If PIPE_LAT=0, DRAIN is bypassed and the completion action below happens directly.
  - DRAIN: out_valid=0. When the counter expires:
    - stage < ADDR_WIDTH-1: stage+1, addr_a=0, count=0, -> ISSUE.
    - otherwise -> IDLE, with done=1 for exactly one cycle (the first IDLE cycle).
- First out_valid appears 1 cycle after start is sampled.
- Outputs are registered. While out_valid=1 and out_ready=0, addr_a, addr_b, tw_idx, stage and last hold stable.
- Address advance on handshake, with s=stage:
  - jump = AND of addr_a[s-1:0]; for s=0, jump=1.
  - next addr_a = addr_a + 1 + (jump ? 2^s : 0), modulo 2^ADDR_WIDTH.
- addr_b = addr_a | 2^s; bit s of addr_a is always 0.
- tw_idx = (addr_a & (2^s - 1)) << (ADDR_WIDTH-1-s), truncated to ADDR_WIDTH-1 bits.
- Butterfly counter: ADDR_WIDTH-1 bits. last = counter all ones, i.e. the 2^(ADDR_WIDTH-1)-th butterfly. The counter wraps to 0 at the stage change.
- start while busy is ignored. start in the same cycle done=1 is accepted (state is IDLE).
- out_ready while out_valid=0 has no effect.
- Total cycles with out_ready held at 1: ADDR_WIDTH*(2^(ADDR_WIDTH-1) + PIPE_LAT), plus 1 for the done pulse.
- No arithmetic overflow beyond the defined modulo wrap. A stage counter value of ADDR_WIDTH or above is never reached.

Test Plan:
- Stage 0 addresses (ADDR_WIDTH=3, PIPE_LAT=2, out_ready=1, pulse start): stage 0 issues (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0, last on the 4th request.
- Stage 1 follows after exactly 2 idle cycles: (0,2) tw0, (1,3) tw2, (4,6) tw0, (5,7) tw2.
- Stage 2: (0,4) tw0, (1,5) tw1, (2,6) tw2, (3,7) tw3. done pulses once, 19 cycles after the start sample.
- Backpressure: same config, out_ready toggled randomly -> identical request sequence. Outputs stable during every stall. done delayed by exactly the number of stall cycles.
- ADDR_WIDTH=13, PIPE_LAT=0, out_ready=1:
  - 13 stages × 4096 requests, no gaps between stages.
  - Every address 0..8191 touched exactly once per stage.
  - addr_b - addr_a = 2^stage on every request.
  - done at cycle 53249.
- start asserted during ISSUE and during DRAIN -> ignored; sequence unchanged. start on the done cycle -> new transform begins with stage 0, addr (0,1).
- Reset mid-stage: rst_n low while stage=1 -> out_valid, busy, stage, addr outputs 0 asynchronously. No done pulse. A subsequent start restarts from stage 0.
